// File: rtl/pulse_period_capture.sv
// Input-capture timer: measures clk cycles between consecutive synchronized rising edges of
// pulse_in and publishes each interval with a one-cycle strobe and a sticky overflow flag.
module pulse_period_capture #(
  parameter int WIDTH       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pulse_in,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             armed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   armed_q, armed_d;
  logic                   rise_s;
  logic                   ovf_set_s;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], pulse_in};
  assign sync_dly_d = sync_q[SYNC_STAGES-1];
  assign rise_s     = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

  // Next-state, counter, capture and flag logic; disable overrides everything including a rise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    ovf_set_s = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise_s) begin
            cnt_d   = CNT_ONE;
            state_d = MEAS;
          end else begin
            cnt_d = '0;
          end
        end
        MEAS: begin
          if (rise_s) begin
            // A saturated count is captured as-is, so the period clamps rather than wraps.
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d     = cnt_q + CNT_ONE;
            ovf_set_s = ((cnt_q + CNT_ONE) == CNT_MAX);
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    armed_d = (state_d != IDLE);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      armed_q    <= armed_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;
  assign armed        = armed_q;

endmodule

// File: tb/tb_pulse_period_capture.sv
// Scoreboard bench for pulse_period_capture (WIDTH=4): a timestamp-based reference model pushes
// expected periods at each capture edge and a negedge monitor pops them on period_valid.
module tb_pulse_period_capture;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         pulse_in = 1'b0;
  logic         clear_ovf = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         overflow;
  logic         armed;

  int errors = 0;
  int checks = 0;

  pulse_period_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_in), .clear_ovf(clear_ovf),
    .period(period), .period_valid(period_valid), .overflow(overflow), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin history gives the synchronized rise (pin 2 and 3 edges back),
  // mode is 0=idle 1=waiting for first edge 2=measuring, intervals come from edge timestamps.
  int  exp_q[$];
  int  cyc = 0, last_rise = 0, mode = 0;
  int  exp_period = 0, exp_ovf = 0, exp_armed = 0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = 0; exp_period = 0; exp_ovf = 0; exp_armed = 0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      exp_q.delete();
    end else begin
      logic rise;
      logic set;
      int   p;
      rise = h2 & ~h3;
      set  = 1'b0;
      if (!enable) begin
        mode = 0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (rise) begin
          mode = 2;
          last_rise = cyc;
        end
      end else begin
        if (rise) begin
          p = cyc - last_rise;
          if (p > MAX) p = MAX;
          exp_q.push_back(p);
          exp_period = p;
          last_rise = cyc;
        end else if (cyc - last_rise + 1 == MAX) begin
          set = 1'b1;
        end
      end
      if (set) exp_ovf = 1;
      else if (clear_ovf) exp_ovf = 0;
      exp_armed = (mode != 0) ? 1 : 0;
      h3 = h2; h2 = h1; h1 = pulse_in;
      cyc++;
    end
  end

  // Monitor: compares outputs mid-cycle and consumes the expected-period queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          check("strobe_period", int'(period), exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        check("missing_strobe", 0, exp_q.pop_front());
      end
      check("period_hold", int'(period), exp_period);
      check("overflow", int'(overflow), exp_ovf);
      check("armed", int'(armed), exp_armed);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_edges(input int n, input int interval);
    repeat (n) begin
      pulse_in = 1'b1;
      cycles(1);
      pulse_in = 1'b0;
      cycles(interval - 1);
    end
  endtask

  initial begin
    int rem;
    // Reset and idle hold
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    check("idle_armed", int'(armed), 0);
    check("idle_valid", int'(period_valid), 0);

    // Steady train, then rate change down to the minimum interval
    enable = 1'b1;
    cycles(3);
    pulse_edges(5, 10);
    pulse_edges(1, 10);
    pulse_edges(1, 7);
    pulse_edges(1, 3);
    pulse_edges(2, 2);
    cycles(6);

    // Overflow: 20-cycle gaps saturate; clear held through the set cycle, then a lone clear
    pulse_edges(1, 20);
    clear_ovf = 1'b1;
    pulse_edges(1, 20);
    clear_ovf = 1'b0;
    pulse_edges(1, 5);
    clear_ovf = 1'b1;
    cycles(1);
    clear_ovf = 1'b0;
    cycles(3);

    // Disable mid-interval, then re-enable: first edge arms, second edge measures
    pulse_edges(1, 5);
    enable = 1'b0;
    cycles(4);
    enable = 1'b1;
    cycles(3);
    check("reenable_armed", int'(armed), 1);
    pulse_edges(2, 9);
    pulse_edges(1, 6);

    // Held level produces one rise; edge coinciding with disable gives no capture
    pulse_in = 1'b1;
    cycles(50);
    pulse_in = 1'b0;
    cycles(4);
    pulse_edges(2, 6);
    pulse_in = 1'b1;
    cycles(2);
    enable = 1'b0;
    cycles(1);
    pulse_in = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(3);
    pulse_edges(3, 8);

    // Asynchronous reset in the middle of a measurement
    pulse_edges(1, 4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_armed", int'(armed), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(4);

    // Randomized pulse train with occasional disables and clears
    rem = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rem == 0) begin
        pulse_in = ~pulse_in;
        rem = (i % 1000 < 500) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 14));
      end
      rem--;
      enable    = ($urandom_range(0, 299) != 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      cycles(1);
    end
    enable = 1'b1;
    clear_ovf = 1'b0;
    pulse_in = 1'b0;
    cycles(6);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
